// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - core, key-store and round-datapath signals of the AES round sequencer
interface aes_round_ctrl_if;
    logic         start;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic         err;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         dp_valid;
    logic [127:0] dp_state_out;
    logic         dp_last;
    logic [127:0] dp_result;
    logic         dp_result_valid;

    modport master (
        input  start, plaintext, rk_in, dp_result, dp_result_valid,
        output busy, done, ciphertext, err, rk_idx, dp_valid, dp_state_out, dp_last
    );

    modport slave (
        output start, plaintext, rk_in, dp_result, dp_result_valid,
        input  busy, done, ciphertext, err, rk_idx, dp_valid, dp_state_out, dp_last
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer; AES_CTRL_TIMEOUT_EN adds a WAIT watchdog
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_t         fsm;
    logic [3:0]   round;
    logic [127:0] state_q;
    logic         last_next;

    // dp_last is registered together with rk_idx, so it looks at the round about to be issued
    assign last_next        = (round + 4'd1 == LAST_ROUND);
    assign bus.dp_state_out = state_q;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    // wd_cnt holds the WAIT cycles already spent; the TIMEOUT-th silent cycle fires
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm            <= IDLE;
            round          <= 4'd0;
            state_q        <= '0;
            bus.ciphertext <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.dp_valid   <= 1'b0;
            bus.dp_last    <= 1'b0;
            bus.rk_idx     <= 4'd0;
`ifdef AES_CTRL_TIMEOUT_EN
            bus.err        <= 1'b0;
            wd_cnt         <= '0;
`endif
        end else begin
            bus.done     <= 1'b0;
            bus.dp_valid <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
            bus.err      <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        // rk_idx is 0 here, so rk_in is the whitening key
                        state_q      <= bus.plaintext ^ bus.rk_in;
                        round        <= 4'd1;
                        bus.rk_idx   <= 4'd1;
                        bus.dp_last  <= (LAST_ROUND == 4'd1);
                        bus.dp_valid <= 1'b1;
                        bus.busy     <= 1'b1;
                        fsm          <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef AES_CTRL_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    fsm <= WAIT;
                end
                WAIT: begin
                    if (bus.dp_result_valid) begin
                        state_q <= bus.dp_result;
                        if (round == LAST_ROUND) begin
                            bus.ciphertext <= bus.dp_result;
                            bus.done       <= 1'b1;
                            bus.rk_idx     <= 4'd0;
                            bus.dp_last    <= 1'b0;
                            fsm            <= DONE;
                        end else begin
                            round        <= round + 4'd1;
                            bus.rk_idx   <= round + 4'd1;
                            bus.dp_last  <= last_next;
                            bus.dp_valid <= 1'b1;
                            fsm          <= ISSUE;
                        end
                    end
`ifdef AES_CTRL_TIMEOUT_EN
                    else if (wd_expired) begin
                        bus.err     <= 1'b1;
                        bus.busy    <= 1'b0;
                        bus.rk_idx  <= 4'd0;
                        bus.dp_last <= 1'b0;
                        round       <= 4'd0;
                        fsm         <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    round    <= 4'd0;
                    fsm      <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - bench for aes_round_ctrl with AES reference model and round datapath model
module tb_aes_round_ctrl;
    localparam int NR  = 10;
    localparam int TMO = 64;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT0 = 128'hc6a13b37878f5b826f4f8162a1c8d879;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    aes_round_ctrl_if ifc ();

    aes_round_ctrl #(.NR(NR), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk_tab [0:10];

    assign ifc.rk_in = (ifc.rk_idx <= 4'd10) ? rk_tab[ifc.rk_idx] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input bit last);
        logic [127:0] t;
        logic [127:0] u;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(c*4+r) -: 8] = sbox_t[gb(s, ((c + r) % 4) * 4 + r)];
        u = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = gb(t, c*4);
                a1 = gb(t, c*4+1);
                a2 = gb(t, c*4+2);
                a3 = gb(t, c*4+3);
                u[127-8*(c*4)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                u[127-8*(c*4+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                u[127-8*(c*4+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                u[127-8*(c*4+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return u ^ rk;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, rk_tab[r], r == NR);
        return s;
    endfunction

    // expected operation timeline, all in cycle numbers
    int           op_start_c = 0;
    int           op_end_c = -1;
    int           op_issues = NR;
    bit           op_has_done = 1'b1;
    bit           op_has_err = 1'b0;
    logic [127:0] op_pt = '0;
    logic [127:0] exp_ct = '0;
    int           dp_lat = 1;
    int           glitch_round = 15;
    int           hang_round = 15;
    int           nvalid = 0;

    // datapath model state
    bit           pend;
    int           dcnt;
    logic [3:0]   cap_rk;
    logic [127:0] cap_st;
    logic [127:0] res;

    int rel;
    bit exp_busy, exp_done, exp_err, exp_dpv;

    always @(negedge clk) begin
        if (rst_n) begin
            rel      = cyc - op_start_c;
            exp_busy = (cyc > op_start_c) && (cyc <= op_end_c);
            exp_done = op_has_done && (cyc == op_end_c);
            exp_err  = op_has_err && (cyc == op_end_c + 1);
            exp_dpv  = exp_busy && !exp_done && rel >= 1 && ((rel - 1) % (dp_lat + 1) == 0)
                       && ((rel - 1) / (dp_lat + 1) < op_issues);
            if (exp_done) exp_ct = aes_encrypt(op_pt);
            check("busy", ifc.busy, exp_busy);
            check("done", ifc.done, exp_done);
            check("err", ifc.err, exp_err);
            check("dp_valid", ifc.dp_valid, exp_dpv);
            check("ciphertext", ifc.ciphertext, exp_ct);
            check("dp_last", ifc.dp_last, ifc.rk_idx == 4'(NR));
            if (!ifc.busy) check("idle_rk_idx", ifc.rk_idx, 0);
            if (ifc.dp_valid) begin
                nvalid++;
                check("issue_rk_idx", ifc.rk_idx, nvalid);
            end
            if (ifc.done) check("issue_count", nvalid, NR);
            if (pend) begin
                check("wait_rk_idx_stable", ifc.rk_idx, cap_rk);
                check("wait_state_stable", ifc.dp_state_out, cap_st);
            end
            ifc.dp_result_valid = 1'b0;
            if (pend) begin
                dcnt--;
                if (dcnt == 0) begin
                    ifc.dp_result       = res;
                    ifc.dp_result_valid = 1'b1;
                    pend                = 1'b0;
                end
            end
            if (ifc.dp_valid) begin
                cap_rk = ifc.rk_idx;
                cap_st = ifc.dp_state_out;
                res    = aes_round(ifc.dp_state_out, ifc.rk_in, ifc.dp_last);
                if (int'(ifc.rk_idx) != hang_round) begin
                    pend = 1'b1;
                    dcnt = dp_lat;
                end
                if (int'(ifc.rk_idx) == glitch_round) begin
                    ifc.dp_result       = '1;
                    ifc.dp_result_valid = 1'b1;
                end
            end
        end else begin
            pend                = 1'b0;
            ifc.dp_result_valid = 1'b0;
            ifc.dp_result       = '0;
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_op(input logic [127:0] pt, input int lat, input int issues,
                            input bit has_done, input int end_off, input bit has_err);
        dp_lat        = lat;
        op_pt         = pt;
        op_issues     = issues;
        op_has_done   = has_done;
        op_has_err    = has_err;
        nvalid        = 0;
        op_start_c    = cyc;
        op_end_c      = cyc + end_off;
        ifc.plaintext = pt;
        ifc.start     = 1'b1;
        @(posedge clk);
        #2;
        ifc.start     = 1'b0;
    endtask

    task automatic run_normal(input logic [127:0] pt, input int lat);
        start_op(pt, lat, NR, 1'b1, 1 + NR * (lat + 1), 1'b0);
    endtask

    task automatic abort_op();
        rst_n    = 1'b0;
        op_end_c = cyc - 1;
        exp_ct   = '0;
        #1;
        check("abort_busy", ifc.busy, 0);
        check("abort_ciphertext", ifc.ciphertext, 0);
        check("abort_done", ifc.done, 0);
        check("abort_err", ifc.err, 0);
        wait_until(cyc + 2);
        rst_n = 1'b1;
        wait_until(cyc + 1);
    endtask

    int s;

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        ifc.start     = 1'b0;
        ifc.plaintext = '0;
        build_sbox();
        expand_key(KEY);
        check("model_kat_pt", aes_encrypt(PT), CT1);
        check("model_kat_zero", aes_encrypt('0), CT0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_err", ifc.err, 0);
        check("rst_dp_valid", ifc.dp_valid, 0);
        check("rst_dp_last", ifc.dp_last, 0);
        check("rst_rk_idx", ifc.rk_idx, 0);
        check("rst_ciphertext", ifc.ciphertext, 0);
        check("rst_state", ifc.dp_state_out, 0);
        rst_n = 1'b1;
        wait_until(cyc + 2);

        // known answer, 1-cycle datapath
        s = cyc;
        run_normal(PT, 1);
        wait_until(op_end_c);
        check("kat_l1_done_time", op_end_c - s, 21);
        check("kat_l1_done", ifc.done, 1);
        check("kat_l1_ct", ifc.ciphertext, CT1);
        wait_until(cyc + 3);

        // known answer, 3-cycle datapath
        s = cyc;
        run_normal(PT, 3);
        wait_until(op_end_c);
        check("kat_l3_done", ifc.done, 1);
        check("kat_l3_ct", ifc.ciphertext, CT1);
        wait_until(cyc + 3);

        // stray starts and an ISSUE-cycle result glitch
        glitch_round = 2;
        s = cyc;
        run_normal(PT, 1);
        wait_until(s + 5);
        ifc.start     = 1'b1;
        ifc.plaintext = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        wait_until(s + 6);
        ifc.start = 1'b0;
        wait_until(s + 20);
        ifc.start = 1'b1;
        wait_until(s + 22);
        ifc.start     = 1'b0;
        ifc.plaintext = '0;
        check("stray_ct", ifc.ciphertext, CT1);
        wait_until(cyc + 5);
        check("stray_no_second_op", ifc.busy, 0);
        glitch_round = 15;

        // reset in the middle of an operation, then a clean rerun
        s = cyc;
        run_normal(PT, 1);
        wait_until(s + 12);
        abort_op();
        run_normal(PT, 1);
        wait_until(op_end_c);
        check("after_abort_ct", ifc.ciphertext, CT1);

        // back-to-back start right after done
        wait_until(op_end_c + 1);
        run_normal('0, 1);
        wait_until(op_end_c);
        check("b2b_done", ifc.done, 1);
        check("b2b_ct", ifc.ciphertext, CT0);
        wait_until(cyc + 3);

        // datapath never answers round 3
        hang_round = 3;
`ifdef AES_CTRL_TIMEOUT_EN
        start_op(PT, 1, 3, 1'b0, 1 + 2 * 2 + TMO, 1'b1);
        wait_until(op_end_c + 1);
        check("timeout_err", ifc.err, 1);
        check("timeout_idle", ifc.busy, 0);
        check("timeout_ct_kept", ifc.ciphertext, CT0);
        wait_until(cyc + 3);
`else
        start_op(PT, 1, 3, 1'b0, 100000, 1'b0);
        wait_until(cyc + 100);
        check("hang_busy", ifc.busy, 1);
        check("hang_err", ifc.err, 0);
        abort_op();
`endif
        hang_round = 15;

        // recovery
        run_normal(PT, 1);
        wait_until(op_end_c);
        check("final_ct", ifc.ciphertext, CT1);
        wait_until(cyc + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
